// File: rtl/eth_pkg.sv
// Shared types and defaults for the Ethernet transmit frame scheduler.
package eth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      GAP
   } state_t;

   // 12 octets of inter-frame gap, sent as two nibbles each
   localparam int ETH_IFG_NIBBLES     = 24;
   localparam int ETH_TIMEOUT_DEFAULT = 4096;
   localparam int ETH_SEQ_W           = 16;

endpackage

// File: rtl/eth_tx_frame_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the buffer not served last.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant_idx,
   output logic       grant_valid
);

   logic last_served;

   always_comb begin
      grant_valid = |req;
      if (&req) grant_idx = ~last_served;
      else      grant_idx = req[1];
   end

   // Reset to 1 so buffer 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst)          last_served <= 1'b1;
      else if (advance) last_served <= grant_idx;
   end

endmodule

// File: rtl/eth_tx_frame_scheduler.sv
// Picks a ready frame buffer, starts the nibble transmitter, waits for finish
// or timeout, enforces the inter-frame gap and releases the buffer.
module eth_tx_frame_scheduler
   import eth_pkg::*;
#(
   parameter int IFG_CYCLES     = ETH_IFG_NIBBLES,
   parameter int TIMEOUT_CYCLES = ETH_TIMEOUT_DEFAULT,
   parameter int SEQ_W          = ETH_SEQ_W
) (
   input  logic             ETH_TX_CLK,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       buf_ready,
   output logic [1:0]       buf_release,
   output logic             buf_sel,
   output logic             tx_start,
   input  logic             tx_finish,
   output logic [SEQ_W-1:0] frame_seq,
   output logic             busy,
   output logic             timeout_err,
   input  logic             err_clr
);

   localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]        IFG_LAST = 8'(IFG_CYCLES - 1);

   state_t           state, next_state;
   logic [TMR_W-1:0] wait_tmr;
   logic [7:0]       ifg_cnt;
   logic             grant_idx, grant_valid;
   logic             grant_take, timed_out;

   rr_arb2 u_arb (
      .clk         (ETH_TX_CLK),
      .rst         (rst),
      .req         (buf_ready),
      .advance     (grant_take),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_ff @(posedge ETH_TX_CLK) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      grant_take = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && grant_valid) begin
               next_state = START;
               grant_take = 1'b1;
            end
         end
         START: next_state = WAIT;
         WAIT: begin
            // A finish on the last timer cycle still counts as a good frame
            if (tx_finish) begin
               next_state = GAP;
            end else if (wait_tmr == TMR_LAST) begin
               next_state = GAP;
               timed_out  = 1'b1;
            end
         end
         GAP: begin
            if (ifg_cnt == IFG_LAST) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge ETH_TX_CLK) begin
      if (rst) begin
         tx_start    <= 1'b0;
         buf_release <= 2'b00;
         buf_sel     <= 1'b0;
         frame_seq   <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         wait_tmr    <= '0;
         ifg_cnt     <= '0;
      end else begin
         tx_start    <= grant_take;
         busy        <= (next_state != IDLE);
         buf_release <= 2'b00;

         if (grant_take) buf_sel <= grant_idx;

         if (state == START)     wait_tmr <= '0;
         else if (state == WAIT) wait_tmr <= wait_tmr + 1'b1;

         if (state == WAIT && next_state == GAP) begin
            buf_release <= buf_sel ? 2'b10 : 2'b01;
            frame_seq   <= frame_seq + 1'b1;
            ifg_cnt     <= '0;
         end else if (state == GAP) begin
            ifg_cnt <= ifg_cnt + 1'b1;
         end

         if (timed_out)    timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_eth_tx_frame_scheduler.sv
// Directed bench: dut_a uses default gap/timeout, dut_b a short gap and timeout.
module tb_eth_tx_frame_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_enable, a_tx_finish, a_err_clr;
   logic [1:0]  a_buf_ready, a_buf_release;
   logic        a_buf_sel, a_tx_start, a_busy, a_timeout_err;
   logic [15:0] a_frame_seq;

   logic        b_rst, b_enable, b_tx_finish, b_err_clr;
   logic [1:0]  b_buf_ready, b_buf_release;
   logic        b_buf_sel, b_tx_start, b_busy, b_timeout_err;
   logic [15:0] b_frame_seq;

   int n_checks = 0;
   int n_fail   = 0;

   eth_tx_frame_scheduler #(.IFG_CYCLES(24), .TIMEOUT_CYCLES(4096), .SEQ_W(16)) dut_a (
      .ETH_TX_CLK (clk),
      .rst         (a_rst),
      .enable      (a_enable),
      .buf_ready   (a_buf_ready),
      .buf_release (a_buf_release),
      .buf_sel     (a_buf_sel),
      .tx_start    (a_tx_start),
      .tx_finish   (a_tx_finish),
      .frame_seq   (a_frame_seq),
      .busy        (a_busy),
      .timeout_err (a_timeout_err),
      .err_clr     (a_err_clr)
   );

   eth_tx_frame_scheduler #(.IFG_CYCLES(2), .TIMEOUT_CYCLES(16), .SEQ_W(16)) dut_b (
      .ETH_TX_CLK (clk),
      .rst         (b_rst),
      .enable      (b_enable),
      .buf_ready   (b_buf_ready),
      .buf_release (b_buf_release),
      .buf_sel     (b_buf_sel),
      .tx_start    (b_tx_start),
      .tx_finish   (b_tx_finish),
      .frame_seq   (b_frame_seq),
      .busy        (b_busy),
      .timeout_err (b_timeout_err),
      .err_clr     (b_err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wait_start(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!a_tx_start && n < 64);
      check(tag, a_tx_start, 1);
   endtask

   task automatic a_wait_idle(input string tag, input logic sel);
      int n   = 0;
      int bad = 0;
      while (a_busy && n < 64) begin
         if (a_buf_sel !== sel) bad++;
         tick();
         n++;
      end
      check({tag, "_idle"}, a_busy, 0);
      check({tag, "_sel_stable"}, bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cnt;
      logic exp_sel;
      logic found;

      a_rst = 1'b1; a_enable = 1'b0; a_buf_ready = 2'b00; a_tx_finish = 1'b0; a_err_clr = 1'b0;
      b_rst = 1'b1; b_enable = 1'b0; b_buf_ready = 2'b00; b_tx_finish = 1'b0; b_err_clr = 1'b0;
      tick();
      tick();

      check("rst_tx_start", a_tx_start, 0);
      check("rst_release", a_buf_release, 0);
      check("rst_buf_sel", a_buf_sel, 0);
      check("rst_frame_seq", a_frame_seq, 0);
      check("rst_busy", a_busy, 0);
      check("rst_err", a_timeout_err, 0);

      // Single buffer: start one cycle after ready, finish 140 cycles later
      a_rst = 1'b0; a_enable = 1'b1; a_buf_ready = 2'b01;
      tick();
      check("sb_start", a_tx_start, 1);
      check("sb_sel", a_buf_sel, 0);
      check("sb_busy", a_busy, 1);
      tick();
      check("sb_start_width", a_tx_start, 0);
      cnt = 0;
      repeat (139) begin
         tick();
         if (a_tx_start || a_buf_release != 2'b00) cnt++;
      end
      check("sb_wait_quiet", cnt, 0);
      a_tx_finish = 1'b1;
      tick();
      a_tx_finish = 1'b0;
      check("sb_release", a_buf_release, 2'b01);
      check("sb_seq", a_frame_seq, 1);
      check("sb_err", a_timeout_err, 0);
      a_buf_ready = 2'b00;
      cnt = 0;
      while (a_busy && cnt < 100) begin
         cnt++;
         tick();
         if (cnt == 1) check("sb_release_width", a_buf_release, 2'b00);
      end
      check("sb_gap_busy_cycles", cnt, 24);

      // Round-robin with both buffers held ready
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0; a_buf_ready = 2'b11;
      for (int f = 0; f < 4; f++) begin
         exp_sel = f[0];
         a_wait_start($sformatf("rr%0d_start", f));
         check($sformatf("rr%0d_sel", f), a_buf_sel, exp_sel);
         repeat (5) tick();
         check($sformatf("rr%0d_sel_wait", f), a_buf_sel, exp_sel);
         a_tx_finish = 1'b1;
         tick();
         a_tx_finish = 1'b0;
         check($sformatf("rr%0d_release", f), a_buf_release, exp_sel ? 2'b10 : 2'b01);
         a_wait_idle($sformatf("rr%0d", f), exp_sel);
      end
      check("rr_seq", a_frame_seq, 4);

      // Enable dropped mid-frame: frame completes, then no new start
      a_buf_ready = 2'b01;
      a_wait_start("en_start");
      check("en_sel", a_buf_sel, 0);
      tick();
      a_enable = 1'b0;
      repeat (3) tick();
      a_tx_finish = 1'b1;
      tick();
      a_tx_finish = 1'b0;
      check("en_release", a_buf_release, 2'b01);
      check("en_seq", a_frame_seq, 5);
      cnt = 0;
      repeat (60) begin
         tick();
         if (a_tx_start) cnt++;
      end
      check("en_blocked", cnt, 0);
      check("en_idle", a_busy, 0);
      a_enable = 1'b1;
      a_wait_start("en_resume");
      check("en_resume_sel", a_buf_sel, 0);
      tick();
      a_tx_finish = 1'b1;
      tick();
      a_tx_finish = 1'b0;
      a_buf_ready = 2'b10;
      a_wait_idle("en_resume", 1'b0);
      check("en_resume_seq", a_frame_seq, 6);

      // Reset ten cycles into WAIT, then the same buffer restarts
      a_wait_start("rs_start");
      check("rs_sel", a_buf_sel, 1);
      repeat (10) tick();
      a_rst = 1'b1;
      tick();
      check("rs_tx_start", a_tx_start, 0);
      check("rs_release", a_buf_release, 0);
      check("rs_sel_reset", a_buf_sel, 0);
      check("rs_seq", a_frame_seq, 0);
      check("rs_busy", a_busy, 0);
      a_rst = 1'b0;
      tick();
      check("rs_restart", a_tx_start, 1);
      check("rs_restart_sel", a_buf_sel, 1);
      check("rs_restart_seq", a_frame_seq, 0);
      a_enable = 1'b0; a_buf_ready = 2'b00;

      // Timeout with TIMEOUT_CYCLES=16: WAIT lasts 16 cycles, release follows
      b_rst = 1'b0; b_enable = 1'b1; b_buf_ready = 2'b01;
      tick();
      check("to_start", b_tx_start, 1);
      cnt = 0;
      repeat (16) begin
         tick();
         if (b_buf_release != 2'b00 || b_timeout_err) cnt++;
      end
      check("to_quiet", cnt, 0);
      tick();
      check("to_release", b_buf_release, 2'b01);
      check("to_err", b_timeout_err, 1);
      check("to_seq", b_frame_seq, 1);
      b_buf_ready = 2'b00;
      tick();
      tick();
      check("to_err_sticky", b_timeout_err, 1);
      b_err_clr = 1'b1;
      tick();
      b_err_clr = 1'b0;
      check("to_err_clr", b_timeout_err, 0);

      // err_clr held across a second timeout: set wins
      b_buf_ready = 2'b01; b_err_clr = 1'b1;
      tick();
      repeat (17) tick();
      check("to2_release", b_buf_release, 2'b01);
      check("to2_set_wins", b_timeout_err, 1);
      b_err_clr = 1'b0; b_buf_ready = 2'b00;
      tick();
      tick();
      b_err_clr = 1'b1;
      tick();
      b_err_clr = 1'b0;
      check("to2_err_clr", b_timeout_err, 0);

      // Finish on the timeout cycle: good frame, no error
      b_buf_ready = 2'b01;
      tick();
      repeat (16) tick();
      b_tx_finish = 1'b1;
      tick();
      b_tx_finish = 1'b0;
      check("tf_release", b_buf_release, 2'b01);
      check("tf_no_err", b_timeout_err, 0);
      check("tf_seq", b_frame_seq, 3);
      b_buf_ready = 2'b00;
      tick();
      tick();
      check("tf_idle", b_busy, 0);

      // IFG_CYCLES=2, producer re-raises ready one cycle after release
      b_buf_ready = 2'b01;
      tick();
      check("gb_start", b_tx_start, 1);
      tick();
      b_tx_finish = 1'b1;
      cnt   = 0;
      found = 1'b0;
      while (cnt < 20 && !found) begin
         tick();
         cnt++;
         if (cnt == 1) begin
            b_tx_finish = 1'b0;
            check("gb_release", b_buf_release, 2'b01);
            b_buf_ready = 2'b00;
         end else if (cnt == 2) begin
            b_buf_ready = 2'b01;
         end
         if (b_tx_start) found = 1'b1;
      end
      check("gb_found", found, 1);
      check("gb_start_delay", cnt, 4);
      check("gb_seq", b_frame_seq, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
